// File: rtl/reg_dump_tx_if.sv
// rtl/reg_dump_tx_if.sv - register-file read port and UART/status bundle for reg_dump_tx
interface reg_dump_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [4:0]            rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  tx;
    logic                  busy;
    logic                  done;

    // Dump engine side
    modport master (
        input  start,
        input  rd_data,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

    // Register file / host side
    modport slave (
        output start,
        output rd_data,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - walks x0..x31 through a spare read port and streams them as UART 8N1
module reg_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32
) (
    input logic          clk,
    input logic          reset,
    reg_dump_tx_if.master bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
    localparam logic [7:0]    HEADER    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         bit_cnt;
    logic [2:0]            bit_idx;
    logic [BW-1:0]         byte_idx;
    logic                  hdr;
    logic [7:0]            byte_sh;
    logic [DATA_WIDTH-1:0] word_sh;
    logic [4:0]            addr;
    logic                  done_r;
    logic                  tx_line;
    logic                  bit_end;
    logic                  last_byte;
    logic                  last_reg;

    assign bit_end   = (bit_cnt == BIT_LAST);
    assign last_byte = (byte_idx == BYTE_LAST);
    assign last_reg  = (addr == 5'd31);

    assign bus.tx      = tx_line;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.rd_addr = addr;

    // State register; reset drops straight to IDLE so tx/busy follow without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and serial line level for the current bit slot
    always_comb begin
        state_next = state;
        tx_line    = 1'b1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = START_BIT;
                end
            end
            LOAD: begin
                state_next = START_BIT;
            end
            START_BIT: begin
                tx_line = 1'b0;
                if (bit_end) begin
                    state_next = DATA_BITS;
                end
            end
            DATA_BITS: begin
                tx_line = byte_sh[0];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    if (hdr) begin
                        state_next = LOAD;
                    end else if (!last_byte) begin
                        state_next = START_BIT;
                    end else if (last_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timing, byte/word shifters, register address and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            hdr      <= 1'b0;
            byte_sh  <= '0;
            word_sh  <= '0;
            addr     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    if (bus.start) begin
                        byte_sh <= HEADER;
                        hdr     <= 1'b1;
                        addr    <= '0;
                    end
                end
                LOAD: begin
                    // Snapshot taken here; later writes to this register do not reach the line
                    byte_sh  <= bus.rd_data[DATA_WIDTH-1 -: 8];
                    word_sh  <= bus.rd_data << 8;
                    byte_idx <= '0;
                end
                START_BIT: begin
                    bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        byte_sh <= byte_sh >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (hdr) begin
                            hdr <= 1'b0;
                        end else if (!last_byte) begin
                            byte_sh  <= word_sh[DATA_WIDTH-1 -: 8];
                            word_sh  <= word_sh << 8;
                            byte_idx <= byte_idx + 1'b1;
                        end else if (last_reg) begin
                            done_r <= 1'b1;
                            addr   <= '0;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb/tb_reg_dump_tx.sv - scoreboard bench for reg_dump_tx: UART decoder plus done-timing monitor
module tb_reg_dump_tx;
    localparam int CPB       = 4;
    localparam int DW        = 32;
    localparam int FRAME_CYC = 129 * 10 * CPB + 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] regs [32];
    logic [7:0]    exp_q [$];
    int            done_q [$];

    reg_dump_tx_if #(.DATA_WIDTH(DW)) bus ();

    reg_dump_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    assign bus.rd_data = regs[bus.rd_addr];

    always #5 clk = ~clk;

    // Cycle index: value k after the k-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void push_frame();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) begin
            for (int b = DW / 8 - 1; b >= 0; b--) begin
                exp_q.push_back(regs[i][8*b +: 8]);
            end
        end
    endfunction

    // UART receiver: negedge-sampled, mid-bit decode, compares each byte against the queue
    logic       rx_act  = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (bus.tx == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 2) begin
                check("rx_start_bit", 32'(bus.tx), 32'd0);
            end else if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0) begin
                rx_byte[3'((rx_cnt - 6) / 4)] <= bus.tx;
            end else if (rx_cnt == 38) begin
                check("rx_stop_bit", 32'(bus.tx), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_byte: got unexpected byte %0h with nothing expected", rx_byte);
                end else begin
                    check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                end
                rx_act <= 1'b0;
            end
        end
    end

    // done monitor: pulse width, busy coincidence and frame timing
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (bus.done) begin
            check("done_busy_low", 32'(bus.busy), 32'd0);
            if (done_d) begin
                checks++;
                errors++;
                $display("FAIL done_width: got done high 2+ cycles expected 1");
            end
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                check("done_time", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
        done_d <= bus.done;
    end

    int acc;

    task automatic accept_and_track(input bit track);
        acc = cyc;
        check("accept_busy", 32'(bus.busy), 32'd1);
        check("accept_tx", 32'(bus.tx), 32'd0);
        if (track) begin
            push_frame();
            done_q.push_back(acc + FRAME_CYC);
        end
    endtask

    task automatic start_frame(input bit hold, input bit track);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        accept_and_track(track);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done within 6000 cycles expected done");
        end
    endtask

    task automatic wait_addr(input logic [4:0] a);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (bus.rd_addr != a && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.rd_addr != a) begin
            checks++;
            errors++;
            $display("FAIL wait_addr: got rd_addr %0d expected %0d", bus.rd_addr, a);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, 32'(bus.tx), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    endtask

    logic [7:0] hdr_bits;
    int         bad;

    initial begin
        bus.start = 1'b0;
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1122_3300 + 32'(i);
        hdr_bits = 8'hA5;

        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // Reset in the middle of the header's data bits: untracked frame
        start_frame(1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #3 reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'd0);

        // Full dump with exact header waveform and first LOAD
        start_frame(1'b0, 1'b1);
        for (int c = 0; c <= 41; c++) begin
            @(negedge clk);
            if (c < 4)       check("hdr_wave", 32'(bus.tx), 32'd0);
            else if (c < 36) check("hdr_wave", 32'(bus.tx), 32'(hdr_bits[(c - 4) / 4]));
            else if (c < 41) check("hdr_wave", 32'(bus.tx), 32'd1);
            else             check("x0_start", 32'(bus.tx), 32'd0);
            if (c == 40) check("load_rd_addr", 32'(bus.rd_addr), 32'd0);
        end
        wait_done();

        // Snapshot: x2 changes right after its LOAD edge
        regs[2] = 32'h0000_0005;
        start_frame(1'b0, 1'b1);
        wait_addr(5'd2);
        @(posedge clk);
        #1 regs[2] = 32'h0000_0009;
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (bus.rd_addr !== 5'd2) bad++;
        end
        check("x2_addr_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 check("x3_addr_next", 32'(bus.rd_addr), 32'd3);
        wait_done();
        regs[2] = 32'h1122_3302;

        // start pulses while busy are dropped
        start_frame(1'b0, 1'b1);
        repeat (100) @(posedge clk);
        pulse_start();
        repeat (2000) @(posedge clk);
        pulse_start();
        repeat (2500) @(posedge clk);
        pulse_start();
        wait_done();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        check("no_second_frame", 32'(bad), 32'd0);
        check("busy_frame_drained", 32'(exp_q.size()), 32'd0);

        // start held high: next frame on the cycle after done
        start_frame(1'b1, 1'b1);
        wait_done();
        @(posedge clk);
        #1;
        accept_and_track(1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // Reset during register 17, then a fresh frame
        start_frame(1'b0, 1'b1);
        wait_addr(5'd17);
        repeat (50) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_x17");
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        start_frame(1'b0, 1'b1);
        wait_done();

        repeat (50) @(posedge clk);
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
